column_scan_driver: RTL

//  Downstream stage of the 7-bit character/column renderer. Captures the 8-bit
//  LED column bytes that the renderer emits one per clock. Buffers the last
//  NUM_COLS columns as a scrolling window. Row-multiplexes the window onto a

---
 rtl/column_scan_driver.sv | 106 ++++++++++
 1 files changed

// File: rtl/column_scan_driver.sv
// Scrolling column window with shadow/display double buffer, row-multiplexed onto an LED matrix.
// Optional GHOST_BLANK_EN blanks row_sel_o/col_out_o on the last cycle of every row.
module column_scan_driver #(
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [7:0]                        col_in_i,
  input  logic                              col_valid_i,
  input  logic                              clear_i,
  output logic [ROWS-1:0]                   row_sel_o,
  output logic [NUM_COLS-1:0]               col_out_o,
  output logic                              frame_start_o,
  output logic [$clog2(NUM_COLS+1)-1:0]     col_count_o
);

  localparam int unsigned CntW = $clog2(NUM_COLS + 1);
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(NUM_COLS);

  logic [DivW-1:0]                div_q, div_d;
  logic [RowW-1:0]                row_q, row_d;
  logic [NUM_COLS-1:0][7:0]       shadow_q, shadow_d;
  logic [NUM_COLS-1:0][7:0]       display_q, display_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           fs_q, fs_d;
  logic                           row_end;
  logic                           frame_end;

  always_comb begin
    row_end   = (div_q == DivLast);
    frame_end = row_end && (row_q == RowLast);

    div_d = row_end ? '0 : div_q + 1'b1;
    row_d = row_q;
    if (row_end) begin
      row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end

    // Display snapshots the pre-shift shadow, so a coinciding push lands a frame later.
    display_d = frame_end ? shadow_q : display_q;
    fs_d      = frame_end;

    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (col_valid_i) begin
      for (int unsigned i = 0; i < NUM_COLS - 1; i++) begin
        shadow_d[i] = shadow_q[i+1];
      end
      shadow_d[NUM_COLS-1] = col_in_i;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      row_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      cnt_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      row_q     <= row_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      cnt_q     <= cnt_d;
      fs_q      <= fs_d;
    end
  end

  always_comb begin
    row_sel_o = ROWS'(1) << row_q;
    col_out_o = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      col_out_o[c] = display_q[c][row_q];
    end
`ifdef GHOST_BLANK_EN
    if (row_end) begin
      row_sel_o = '0;
      col_out_o = '0;
    end
`else
`endif
  end

  assign frame_start_o = fs_q;
  assign col_count_o   = cnt_q;

  // Column bits above ROWS are kept in the buffers but never reach the matrix.
  logic unused_display;
  assign unused_display = ^display_q;

endmodule
